// File: rtl/csa_pkg.sv
// Shared constants and state encoding for the nibble-serial add/subtract unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package csa_pkg;

    // Width of one carry-select slice processed per clock.
    localparam int SLICE_W = 4;

    // Sequencer states of the serial datapath.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_slice4.sv
// 4-bit carry-select adder slice: two ripple chains (cin=0/1) muxed by c_in.
// Latency: purely combinational.
// Backpressure: not applicable.
module csa_slice4
    import csa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum,
    output logic               c_out,
    output logic               c_msb
);

    // Both carry-in cases ripple in parallel; the late-arriving c_in only drives the final mux.
    always_comb begin
        logic [SLICE_W:0]   k0;
        logic [SLICE_W:0]   k1;
        logic [SLICE_W-1:0] s0;
        logic [SLICE_W-1:0] s1;
        k0    = '0;
        k1    = '0;
        s0    = '0;
        s1    = '0;
        k0[0] = 1'b0;
        k1[0] = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            s0[i]   = a[i] ^ b[i] ^ k0[i];
            k0[i+1] = (a[i] & b[i]) | (a[i] & k0[i]) | (b[i] & k0[i]);
            s1[i]   = a[i] ^ b[i] ^ k1[i];
            k1[i+1] = (a[i] & b[i]) | (a[i] & k1[i]) | (b[i] & k1[i]);
        end
        sum   = c_in ? s1 : s0;
        c_out = c_in ? k1[SLICE_W] : k0[SLICE_W];
        c_msb = c_in ? k1[SLICE_W-1] : k0[SLICE_W-1];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract: one 4-bit carry-select slice per clock, LSB slice first.
// Latency: accept at edge k, out_valid rises after edge k+WIDTH/4; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds result and flags until out_ready.
module nibble_serial_addsub
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    // WIDTH is expected to be a multiple of SLICE_W and at least two slices wide.
    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sub_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

    // Pick the current slice of the latched operands; subtraction adds ~b with carry preset to 1.
    always_comb begin
        slice_a = a_q[int'(cnt) * SLICE_W +: SLICE_W];
        slice_b = b_q[int'(cnt) * SLICE_W +: SLICE_W];
        if (sub_q) begin
            slice_b = ~slice_b;
        end
    end

    csa_slice4 u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Sequencer with registered handshake outputs; result is overwritten slice by slice in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        sub_q    <= sub;
                        carry_q  <= sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[int'(cnt) * SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (cnt == LAST_SLICE) begin
                        // The top slice supplies both the final carry and the sign-bit carries.
                        c_out     <= slice_cout;
                        overflow  <= slice_cmsb ^ slice_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with a queue-based result scoreboard.
// Latency: checks out_valid appears exactly 4 cycles after acceptance (WIDTH=16).
// Backpressure: holds out_ready low in DONE and scrambles inputs during RUN.
module tb_nibble_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        c_out;
    logic        overflow;

    int   checks;
    int   errors;
    exp_t sb[$];

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic built from wide integer math, independent of slicing.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        exp_t        e;
        logic [16:0] wide;
        if (sv) begin
            wide = {1'b0, av} - {1'b0, bv};
            e.res = wide[15:0];
            e.co  = (av >= bv);
            e.ov  = (av[15] != bv[15]) && (e.res[15] != av[15]);
        end else begin
            wide = {1'b0, av} + {1'b0, bv};
            e.res = wide[15:0];
            e.co  = wide[16];
            e.ov  = (av[15] == bv[15]) && (e.res[15] != av[15]);
        end
        return e;
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input int hold);
        int          cyc;
        logic        rdy_seen;
        exp_t        e;
        logic [15:0] held_res;
        logic        held_co;
        logic        held_ov;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        sub      = sv;
        in_valid = 1'b1;
        sb.push_back(model(av, bv, sv));
        @(negedge clk);
        cyc      = 0;
        rdy_seen = 1'b0;
        // Scramble operand inputs while busy; the latched pair must be unaffected.
        while (out_valid !== 1'b1 && cyc < 20) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (in_ready !== 1'b0) rdy_seen = 1'b1;
        check("latency", 32'(cyc), 32'd4);
        check("in_ready_busy", 32'(rdy_seen), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("c_out", 32'(c_out), 32'(e.co));
            check("overflow", 32'(overflow), 32'(e.ov));
        end
        held_res = result;
        held_co  = c_out;
        held_ov  = overflow;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(held_res));
            check("hold_flags", {30'd0, c_out, overflow}, {30'd0, held_co, held_ov});
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic vld_seen;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {30'd0, c_out, overflow}, 32'd0);
        reset = 1'b0;

        run_op(16'h1234, 16'h0FED, 1'b0, 0);
        run_op(16'h1234, 16'h0235, 1'b1, 0);
        run_op(16'h0000, 16'h0001, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 3);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), i % 2);
        end

        // Reset two cycles into RUN must abort the operation with no result.
        @(negedge clk);
        a        = 16'hABCD;
        b        = 16'h1111;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", {30'd0, c_out, overflow}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        vld_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vld_seen = 1'b1;
        end
        check("midrst_no_valid", 32'(vld_seen), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle add/subtract unit that processes a WIDTH-bit operand pair one 4-bit slice per clock, least-significant slice first. Each slice uses a single carry-select 4-bit stage. The carry or borrow between slices is held in a register. The block sits beside the combinational carry-select adders as the area-lean datapath option. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- clk  input  1  rising-edge clock; the block uses one clock only
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- sub  input  1  0 selects a+b; 1 selects a−b
- out_valid  output  1  result, c_out and overflow are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- c_out  output  1  final carry; when sub=1, 1 means no borrow (a ≥ b unsigned)
- overflow  output  1  two's-complement overflow

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b and sub, preset the carry register to sub, clear the slice counter, and go to RUN.
  - RUN: each cycle adds slice i of a to slice i of (sub ? ~b : b), using the carry register as the slice carry-in. The 4-bit result is written into result[4i+3:4i] and the slice carry-out into the carry register. After slice N−1 (N=WIDTH/4), go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Slice computation: the slice computes both carry-in cases in parallel and selects between them using the registered carry.
- c_out: the carry out of slice N−1.
- overflow: the carry into bit WIDTH−1 XOR the carry out of bit WIDTH−1, both captured during the last slice.
- Operand latching: inputs are sampled only on the acceptance edge. Changes to a, b or sub during RUN or DONE have no effect.
- in_ready and out_valid are never high in the same cycle. After out_ready is accepted in DONE, the earliest next accept is the following cycle.
- Stable outputs: result, c_out and overflow hold steady while out_valid is high. They keep their last values in IDLE and are overwritten slice by slice during RUN.
- Slice counter: width is clog2(N). It wraps to 0 only on the transition back to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, c_out=0, overflow=0, state=IDLE, carry register=0, slice counter=0.
- Latency: operands are accepted at edge k. out_valid rises after edge k+N (k+4 for WIDTH=16).
- Throughput: at most one operation every N+2 cycles when out_ready is held high.
- Backpressure: out_ready low in DONE holds the state and outputs indefinitely.
- Reset mid-operation: reset asserted during RUN or DONE returns the block to IDLE immediately (asynchronously) with the reset values above. The in-flight result is discarded and no out_valid pulse is produced.
- in_valid while not in IDLE: ignored; no operand is lost because in_ready is low.

## Structure
- Shared package csa_pkg holds:
  - SLICE_W=4
  - the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
- Sub-module csa_slice4 (combinational):
  - inputs: a[3:0], b[3:0], c_in
  - outputs: sum[3:0], c_out, c_msb (the carry into bit 3)
  - built as two 4-bit ripple adders with carry-in 0 and 1, plus a 2:1 select on c_in
- The top level contains the FSM, the operand registers, the carry register, the slice counter and the result register.

## Test plan
All scenarios use WIDTH=16.
- Add: a=0x1234, b=0x0FED, sub=0 → result=0x2221, c_out=0, overflow=0; out_valid rises exactly 4 cycles after acceptance.
- Subtract, no borrow: a=0x1234, b=0x0235, sub=1 → result=0x0FFF, c_out=1, overflow=0.
- Subtract, borrow: a=0x0000, b=0x0001, sub=1 → result=0xFFFF, c_out=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 → result=0x7FFF, c_out=1, overflow=1.
- Signed add overflow: a=0x7FFF, b=0x0001, sub=0 → result=0x8000, overflow=1, c_out=0.
- Backpressure and hold:
  - Hold out_ready low for 3 cycles in DONE: result and flags stay stable and out_valid stays high.
  - Change a and b mid-RUN: the result still matches the latched operands.
  - in_ready must stay low from acceptance through DONE.
- Reset mid-RUN: assert reset 2 cycles after acceptance → all outputs go to their reset values immediately, in_ready=1, and no out_valid pulse follows. A subsequent 0x0001+0x0001 returns 0x0002.
